// File: rtl/aec_arbiter.sv
// Round-robin arbiter sharing one AEC expression-evaluator core among N requesters.
// Optional WAIT-state timeout is enabled by defining AEC_TIMEOUT_EN.
module aec_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [8*N-1:0]   ascii_in,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     resp_valid,
   output logic [N-1:0]     resp_err,
   output logic [6:0]       resp_data,
   output logic             busy,
   output logic             core_rst,
   output logic             core_ready,
   output logic [7:0]       core_ascii,
   input  logic             core_valid,
   input  logic [6:0]       core_result
);

   localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RESP = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;
   localparam logic [7:0] EQ_CHAR = 8'd61;
   localparam logic [4:0] CNT_MAX = 5'(MAX_LEN);

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] sel_q, sel_d, last_q, last_d;
   logic [N-1:0]  gnt_q, gnt_d, rv_q, rv_d, re_q, re_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          trunc_q, trunc_d, abort_q, abort_d;
   logic [6:0]    data_q, data_d;
   logic [7:0]    cur_char;
   logic          pick_found;
   logic [SW-1:0] pick_idx, cand_idx;

`ifdef AEC_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wcnt_q, wcnt_d;
   logic          timeout_w;
`endif

   assign cur_char = ascii_in[{sel_q, 3'b000} +: 8];

   // Search last+1 .. last+N (mod N) so the most recently served requester goes last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand_idx = SW'((32'(last_q) + k) % N);
         if (!pick_found && req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      trunc_d    = trunc_q;
      abort_d    = abort_q;
      rv_d       = '0;
      re_d       = '0;
      data_d     = data_q;
      core_ascii = '0;
      core_ready = 1'b0;
`ifdef AEC_TIMEOUT_EN
      wcnt_d     = wcnt_q;
      timeout_w  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               sel_d           = pick_idx;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               cnt_d           = '0;
               trunc_d         = 1'b0;
               abort_d         = 1'b0;
               state_d         = S_SEND;
            end
         end
         S_SEND: begin
            core_ready = (cnt_q == 5'd0);
            core_ascii = cur_char;
            if (!req[sel_q] || cur_char == EQ_CHAR || cnt_q == CNT_MAX) begin
               // A dropped request or full buffer still terminates the core's expression.
               if (!req[sel_q]) begin
                  core_ascii = EQ_CHAR;
                  abort_d    = 1'b1;
               end else if (cur_char != EQ_CHAR) begin
                  core_ascii = EQ_CHAR;
                  trunc_d    = 1'b1;
               end
               gnt_d   = '0;
               state_d = S_WAIT;
`ifdef AEC_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_WAIT: begin
            if (core_valid) begin
               data_d = core_result;
               if (trunc_q || abort_q) re_d[sel_q] = 1'b1;
               else                    rv_d[sel_q] = 1'b1;
               state_d = S_RESP;
            end
`ifdef AEC_TIMEOUT_EN
            else if (wcnt_q == TW'(TIMEOUT - 1)) begin
               timeout_w   = 1'b1;
               data_d      = '0;
               re_d[sel_q] = 1'b1;
               state_d     = S_RESP;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            last_d  = sel_q;
            state_d = S_GAP;
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         last_q  <= SW'(N - 1);
         gnt_q   <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
         abort_q <= 1'b0;
         rv_q    <= '0;
         re_q    <= '0;
         data_q  <= '0;
`ifdef AEC_TIMEOUT_EN
         wcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
         abort_q <= abort_d;
         rv_q    <= rv_d;
         re_q    <= re_d;
         data_q  <= data_d;
`ifdef AEC_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign resp_valid = rv_q;
   assign resp_err   = re_q;
   assign resp_data  = data_q;
   assign busy       = (state_q != S_IDLE);
`ifdef AEC_TIMEOUT_EN
   assign core_rst   = ~rst | timeout_w;
`else
   assign core_rst   = ~rst;
`endif

endmodule
